// File: rtl/systolic_unary_sched_pkg.sv
// Shared types and schedule-geometry helpers for the unary systolic sequencer.
package systolic_unary_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Cycles per phase: full unary sweep of 2^size steps plus two boundary cycles.
  function automatic int unsigned phase_len(input int unsigned size);
    return (32'd1 << size) + 32'd2;
  endfunction

  // Phases between an A row entering lane 0 and its C row leaving the array.
  function automatic int unsigned out_lat(input int unsigned a_col, input int unsigned b_col);
    return a_col + b_col - 32'd2;
  endfunction

  // Phases needed to stream every A row in and drain every C row out.
  function automatic int unsigned num_phases(input int unsigned a_row, input int unsigned a_col,
                                             input int unsigned b_col);
    return a_row + out_lat(a_col, b_col);
  endfunction

  // Row index width, with one spare bit of headroom.
  function automatic int unsigned row_w(input int unsigned a_row);
    return $clog2(a_row) + 32'd1;
  endfunction

endpackage

// File: rtl/systolic_unary_sched_phase_counter.sv
// Wrapping counter with enable, clear and terminal-count flag; drives unary_cnt.
module systolic_unary_sched_phase_counter #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned TERM  = 17
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

  logic [WIDTH-1:0] r_cnt;

  // Count up while enabled, wrap to zero after the terminal value.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == TERM_V);

endmodule

// File: rtl/systolic_unary_sched.sv
// Job sequencer for a unary-coded systolic array: sweeps the magnitude counter,
// strobes phase boundaries, and schedules A lanes and C captures per phase.
module systolic_unary_sched
  import systolic_unary_sched_pkg::*;
#(
  parameter  int unsigned SIZE  = 4,
  parameter  int unsigned A_ROW = 2,
  parameter  int unsigned A_COL = 2,
  parameter  int unsigned B_COL = 2,
  localparam int unsigned ROW_W = row_w(A_ROW)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        hold,
  output logic                        busy,
  output logic [SIZE:0]               unary_cnt,
  output logic                        data_clk,
  output logic [A_COL-1:0]            lane_valid,
  output logic [A_COL-1:0][ROW_W-1:0] lane_row,
  output logic                        c_capture,
  output logic [ROW_W-1:0]            c_row,
  output logic                        done
);

  localparam int unsigned PLEN    = phase_len(SIZE);
  localparam int unsigned OUT_LAT = out_lat(A_COL, B_COL);
  localparam int unsigned NUM_PH  = num_phases(A_ROW, A_COL, B_COL);
  localparam int unsigned PW      = $clog2(NUM_PH + 1);
  localparam int unsigned CW      = SIZE + 1;
  localparam logic [PW-1:0] LAST_P = PW'(NUM_PH - 1);

  state_e        r_state;
  logic [PW-1:0] r_p;
  logic          w_run;
  logic          w_adv;
  logic          w_tc;
  logic          w_dclk;
  logic [31:0]   w_pv;

  assign w_run  = (r_state == ST_RUN);
  assign w_adv  = w_run && !hold;
  assign w_dclk = w_adv && w_tc;
  assign w_pv   = 32'(r_p);

  // Magnitude sweep: cleared outside RUN, frozen while held.
  systolic_unary_sched_phase_counter #(
    .WIDTH (CW),
    .TERM  (PLEN - 1)
  ) u_unary_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_adv),
    .i_clr   (!w_run),
    .o_cnt   (unary_cnt),
    .o_tc    (w_tc)
  );

  // Job FSM and phase counter; phase advances only on a phase-boundary strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_p     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_p <= '0;
          if (start && !hold) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_dclk) begin
            r_p <= r_p + PW'(1);
            if (r_p == LAST_P) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Lane j is skewed by j phases: it carries A row (p - j) while that row exists.
  always_comb begin
    lane_valid = '0;
    lane_row   = '0;
    if (w_run) begin
      for (int unsigned j = 0; j < A_COL; j++) begin
        if ((w_pv >= j) && ((w_pv - j) < A_ROW)) begin
          lane_valid[j] = 1'b1;
          lane_row[j]   = ROW_W'(w_pv - j);
        end
      end
    end
  end

  // C row (p - OUT_LAT) reaches the bottom of the array at this phase boundary.
  always_comb begin
    c_capture = w_dclk && (w_pv >= OUT_LAT);
    c_row     = c_capture ? ROW_W'(w_pv - OUT_LAT) : '0;
  end

  assign data_clk = w_dclk;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_systolic_unary_sched.sv
// Scoreboard bench: default-parameter instance checked every cycle against a
// job-level model; a second small-geometry instance checked on its strobes.
module tb_systolic_unary_sched;

  localparam int unsigned SIZE    = 4;
  localparam int unsigned A_ROW   = 2;
  localparam int unsigned A_COL   = 2;
  localparam int unsigned B_COL   = 2;
  localparam int unsigned ROW_W   = $clog2(A_ROW) + 1;
  localparam int unsigned CW      = SIZE + 1;
  localparam int          PL      = (1 << SIZE) + 2;
  localparam int          OUT_LAT = A_COL + B_COL - 2;
  localparam int          NP      = A_ROW + OUT_LAT;

  localparam int unsigned SIZE_B   = 2;
  localparam int unsigned A_ROW_B  = 3;
  localparam int unsigned A_COL_B  = 3;
  localparam int unsigned B_COL_B  = 1;
  localparam int unsigned ROW_W_B  = $clog2(A_ROW_B) + 1;
  localparam int          PL_B     = (1 << SIZE_B) + 2;
  localparam int          OUT_LAT_B = A_COL_B + B_COL_B - 2;
  localparam int          NP_B     = A_ROW_B + OUT_LAT_B;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic start_b = 1'b0;

  logic                        busy, data_clk, c_capture, done;
  logic [SIZE:0]               unary_cnt;
  logic [A_COL-1:0]            lane_valid;
  logic [A_COL-1:0][ROW_W-1:0] lane_row;
  logic [ROW_W-1:0]            c_row;

  logic                            busy_b, data_clk_b, c_capture_b, done_b;
  logic [SIZE_B:0]                 unary_cnt_b;
  logic [A_COL_B-1:0]              lane_valid_b;
  logic [A_COL_B-1:0][ROW_W_B-1:0] lane_row_b;
  logic [ROW_W_B-1:0]              c_row_b;

  systolic_unary_sched #(.SIZE(SIZE), .A_ROW(A_ROW), .A_COL(A_COL), .B_COL(B_COL)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .busy(busy),
    .unary_cnt(unary_cnt), .data_clk(data_clk), .lane_valid(lane_valid),
    .lane_row(lane_row), .c_capture(c_capture), .c_row(c_row), .done(done)
  );

  systolic_unary_sched #(.SIZE(SIZE_B), .A_ROW(A_ROW_B), .A_COL(A_COL_B), .B_COL(B_COL_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .hold(1'b0), .busy(busy_b),
    .unary_cnt(unary_cnt_b), .data_clk(data_clk_b), .lane_valid(lane_valid_b),
    .lane_row(lane_row_b), .c_capture(c_capture_b), .c_row(c_row_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                          n;
    logic                        busy;
    logic                        done;
    logic                        dclk;
    logic                        cap;
    logic [CW-1:0]               cnt;
    logic [A_COL-1:0]            lv;
    logic [A_COL-1:0][ROW_W-1:0] lr;
    logic [ROW_W-1:0]            crow;
  } win_t;

  typedef struct {
    int n;
    bit is_done;
    bit cap;
    int crow;
  } ev_t;

  win_t q[$];
  ev_t  qb[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Job-level model: 0 idle, 1 running (m_act = unheld run cycles so far), 2 done.
  int m_st = 0;
  int m_act = 0;

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, n, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then advance the model.
  task automatic step(input bit rst, input bit st, input bit hd, input bit stb);
    win_t w;
    int   k;
    int   c;
    @(posedge clk);
    #1;
    reset   = rst;
    start   = st;
    hold    = hd;
    start_b = stb;
    w.n = cyc; w.busy = 1'b0; w.done = 1'b0; w.dclk = 1'b0; w.cap = 1'b0;
    w.cnt = '0; w.lv = '0; w.lr = '0; w.crow = '0;
    if (m_st != 0) begin
      w.busy = 1'b1;
      k = (m_st == 1) ? (m_act / PL) : NP;
      c = (m_st == 1) ? (m_act % PL) : 0;
      w.done = (m_st == 2);
      w.cnt  = CW'(c);
      // A row r travels down lane j during phase r + j.
      for (int r = 0; r < A_ROW; r++)
        for (int j = 0; j < A_COL; j++)
          if (r + j == k) begin
            w.lv[j] = 1'b1;
            w.lr[j] = ROW_W'(r);
          end
      w.dclk = (m_st == 1) && !hd && (c == PL - 1);
      if (w.dclk)
        for (int r = 0; r < A_ROW; r++)
          if (r + OUT_LAT == k) begin
            w.cap  = 1'b1;
            w.crow = ROW_W'(r);
          end
    end
    q.push_back(w);
    if (stb && !rst) begin
      for (int p = 0; p < NP_B; p++)
        qb.push_back('{n: cyc + PL_B * (p + 1), is_done: 1'b0,
                       cap: (p >= OUT_LAT_B), crow: (p >= OUT_LAT_B) ? p - OUT_LAT_B : 0});
      qb.push_back('{n: cyc + PL_B * NP_B + 1, is_done: 1'b1, cap: 1'b0, crow: 0});
    end
    if (rst) begin
      m_st = 0; m_act = 0;
    end else begin
      case (m_st)
        0: if (st && !hd) begin m_st = 1; m_act = 0; end
        1: if (!hd) begin
             m_act++;
             if (m_act == PL * NP) m_st = 2;
           end
        default: m_st = 0;
      endcase
    end
  endtask

  // Monitor for the default instance: compare every queued cycle.
  win_t mw;
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].n < cyc) begin
      mw = q.pop_front();
      chk("stale_window", mw.n, 32'(cyc), 32'(mw.n));
    end else if (q.size() != 0 && q[0].n == cyc) begin
      mw = q.pop_front();
      chk("busy",       mw.n, 32'(busy),       32'(mw.busy));
      chk("done",       mw.n, 32'(done),       32'(mw.done));
      chk("unary_cnt",  mw.n, 32'(unary_cnt),  32'(mw.cnt));
      chk("data_clk",   mw.n, 32'(data_clk),   32'(mw.dclk));
      chk("lane_valid", mw.n, 32'(lane_valid), 32'(mw.lv));
      chk("lane_row",   mw.n, 32'(lane_row),   32'(mw.lr));
      chk("c_capture",  mw.n, 32'(c_capture),  32'(mw.cap));
      chk("c_row",      mw.n, 32'(c_row),      32'(mw.crow));
    end
  end

  // Monitor for the small instance: pop an expected event on every strobe.
  ev_t eb;
  always @(negedge clk) begin
    if (qb.size() != 0 && qb[0].n < cyc) begin
      eb = qb.pop_front();
      chk("b_missed_event", eb.n, 32'(cyc), 32'(eb.n));
    end
    if (data_clk_b === 1'b1 || done_b === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_strobe", cyc, 32'(1), 32'(0));
      end else begin
        eb = qb.pop_front();
        chk("b_event_cycle", cyc, 32'(cyc),         32'(eb.n));
        chk("b_done",        cyc, 32'(done_b),      32'(eb.is_done));
        chk("b_c_capture",   cyc, 32'(c_capture_b), 32'(eb.cap));
        chk("b_c_row",       cyc, 32'(c_row_b),     32'(eb.crow));
      end
    end
  end

  initial begin
    int  held;
    bit  hd;
    bit  st;
    bit  rs;
    repeat (2) @(posedge clk);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Start while hold is high in idle must be ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Small-geometry job.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (PL_B * NP_B + 6) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Plain job.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && m_st != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Five-cycle hold at unary_cnt 7 of phase 1, start re-pulsed in phase 2.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    held = 0;
    for (int i = 0; i < 400 && m_st != 0; i++) begin
      hd = (m_st == 1) && (m_act == PL + 7) && (held < 5);
      if (hd) held++;
      st = (m_st == 1) && (m_act == 2 * PL + 3);
      step(1'b0, st, hd, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset at unary_cnt 3 of a fresh job aborts it.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !(m_st == 1 && m_act == 3); i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random starts, holds and occasional resets.
    for (int t = 0; t < 6000; t++) begin
      hd = (m_st != 2) && ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 1999) == 0);
      step(rs, st, hd, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    chk("b_pending_events", cyc, 32'(qb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
